// File: rtl/pixsrv_pkg.sv
// ============================================================================
// pixsrv_pkg : shared defaults and types for pixel_frame_server.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package pixsrv_pkg;

  localparam int PIX_W_DEF   = 3;
  localparam int ADDR_W_DEF  = 11;
  localparam int FRAME_SEQ_W = 8;

  typedef logic bank_t;

  // Bank entries are packed {f, g} with f in the upper half.
  typedef struct packed {
    logic [PIX_W_DEF-1:0] f;
    logic [PIX_W_DEF-1:0] g;
  } pix_pair_t;

endpackage

`default_nettype wire

// File: rtl/pixel_bank.sv
// ============================================================================
// pixel_bank : one frame of {f,g} pairs, one write port, two registered reads
//              (port a returns the f half, port b returns the g half).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_bank #(
  parameter int PIX_W  = 3,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [2*PIX_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [PIX_W-1:0]  o_rdata_a,
  output logic [PIX_W-1:0]  o_rdata_b
);

  localparam int              c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [2*PIX_W-1:0] r_mem [DEPTH];
  logic               w_w_ok;
  logic               w_a_ok;
  logic               w_b_ok;

  assign w_w_ok = ({1'b0, i_waddr}   < c_DEPTH);
  assign w_a_ok = ({1'b0, i_raddr_a} < c_DEPTH);
  assign w_b_ok = ({1'b0, i_raddr_b} < c_DEPTH);

  always_ff @(posedge clk) begin
    if (i_we && w_w_ok) begin
      r_mem[i_waddr[c_IDX_W-1:0]] <= i_wdata;
    end
  end

  // A disabled or out-of-range read yields zero so the top can OR both banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rdata_a <= '0;
      o_rdata_b <= '0;
    end else begin
      o_rdata_a <= (i_re && w_a_ok) ? r_mem[i_raddr_a[c_IDX_W-1:0]][2*PIX_W-1:PIX_W] : '0;
      o_rdata_b <= (i_re && w_b_ok) ? r_mem[i_raddr_b[c_IDX_W-1:0]][PIX_W-1:0] : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pixel_frame_server.sv
// ============================================================================
// pixel_frame_server : ping-pong frame buffer for stereo f/g pixel streams.
//                      Optional frame_seq output with macro PIXSRV_FRAME_SEQ_EN.
// Revision           : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_frame_server
  import pixsrv_pkg::*;
#(
  parameter int PIX_W        = PIX_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int FRAME_PIXELS = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_f_pix,
  input  logic [PIX_W-1:0]  in_g_pix,
  input  logic [ADDR_W-1:0] address_f,
  input  logic [ADDR_W-1:0] address_g,
  output logic [PIX_W-1:0]  getfdata,
  output logic [PIX_W-1:0]  gdata,
  output logic              frame_ready,
`ifdef PIXSRV_FRAME_SEQ_EN
  output logic [FRAME_SEQ_W-1:0] frame_seq,
`endif
  input  logic              frame_done
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(FRAME_PIXELS - 1);

  bank_t             r_wr_bank;
  bank_t             r_rd_bank;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [1:0]        r_full;
  logic [1:0]        w_full_nxt;
  logic              w_xfer;
  logic              w_last;
  logic              w_release;
  logic [PIX_W-1:0]  w_rd_f [2];
  logic [PIX_W-1:0]  w_rd_g [2];

  assign in_ready    = !r_full[r_wr_bank];
  assign frame_ready = r_full[r_rd_bank];
  assign w_xfer      = in_valid && in_ready;
  assign w_last      = (r_wr_addr == c_LAST);
  assign w_release   = frame_done && frame_ready;

  // Completion and release never hit the same bank, so both may apply.
  always_comb begin
    w_full_nxt = r_full;
    if (w_xfer && w_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_release)        w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_addr <= '0;
      r_full    <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
      if (w_xfer) begin
        if (w_last) begin
          r_wr_addr <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_addr <= r_wr_addr + 1'b1;
        end
      end
      if (w_release) r_rd_bank <= ~r_rd_bank;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pixel_bank #(
      .PIX_W (PIX_W),
      .ADDR_W(ADDR_W),
      .DEPTH (FRAME_PIXELS)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_we     (w_xfer && (r_wr_bank == bank_t'(b))),
      .i_waddr  (r_wr_addr),
      .i_wdata  ({in_f_pix, in_g_pix}),
      .i_re     (frame_ready && (r_rd_bank == bank_t'(b))),
      .i_raddr_a(address_f),
      .i_raddr_b(address_g),
      .o_rdata_a(w_rd_f[b]),
      .o_rdata_b(w_rd_g[b])
    );
  end

  assign getfdata = w_rd_f[0] | w_rd_f[1];
  assign gdata    = w_rd_g[0] | w_rd_g[1];

`ifdef PIXSRV_FRAME_SEQ_EN
  logic [FRAME_SEQ_W-1:0] r_seq_cnt;
  logic [FRAME_SEQ_W-1:0] r_bank_seq [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_cnt     <= '0;
      r_bank_seq[0] <= '0;
      r_bank_seq[1] <= '0;
    end else if (w_xfer && w_last) begin
      r_bank_seq[r_wr_bank] <= r_seq_cnt;
      r_seq_cnt             <= r_seq_cnt + 1'b1;
    end
  end

  assign frame_seq = r_bank_seq[r_rd_bank];
`endif

endmodule

`default_nettype wire

// File: tb/tb_pixel_frame_server.sv
// ============================================================================
// tb_pixel_frame_server : directed + random stimulus against a frame-queue model.
// Revision              : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_frame_server;

  localparam int PW = 3;
  localparam int AW = 3;
  localparam int FP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          frame_done = 1'b0;
  logic [PW-1:0] in_f_pix = '0;
  logic [PW-1:0] in_g_pix = '0;
  logic [AW-1:0] address_f = '0;
  logic [AW-1:0] address_g = '0;
  logic          in_ready;
  logic          frame_ready;
  logic [PW-1:0] getfdata;
  logic [PW-1:0] gdata;
`ifdef PIXSRV_FRAME_SEQ_EN
  logic [7:0]    frame_seq;
`endif

  pixel_frame_server #(
    .PIX_W       (PW),
    .ADDR_W      (AW),
    .FRAME_PIXELS(FP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_f_pix   (in_f_pix),
    .in_g_pix   (in_g_pix),
    .address_f  (address_f),
    .address_g  (address_g),
    .getfdata   (getfdata),
    .gdata      (gdata),
    .frame_ready(frame_ready),
`ifdef PIXSRV_FRAME_SEQ_EN
    .frame_seq  (frame_seq),
`endif
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Model: FIFO of completed frames (front = frame being read) plus a partial one.
  typedef struct packed {
    logic [7:0]              seq;
    logic [FP-1:0][PW-1:0]   f;
    logic [FP-1:0][PW-1:0]   g;
  } frame_t;

  frame_t q[$];
  frame_t cur;
  int     cur_n;
  int     seq_cnt;
  int     errors;
  int     checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_f(input logic [AW-1:0] a);
    if (q.size() == 0 || a >= FP) return '0;
    return q[0].f[a[1:0]];
  endfunction

  function automatic logic [PW-1:0] ref_g(input logic [AW-1:0] a);
    if (q.size() == 0 || a >= FP) return '0;
    return q[0].g[a[1:0]];
  endfunction

  task automatic model_reset();
    q.delete();
    cur     = '0;
    cur_n   = 0;
    seq_cnt = 0;
  endtask

  // Called #1 after a rising edge; returns #1 after the next rising edge.
  task automatic cycle(input logic v, input logic [PW-1:0] f, input logic [PW-1:0] g,
                       input logic [AW-1:0] af, input logic [AW-1:0] ag, input logic d);
    logic [PW-1:0] ef;
    logic [PW-1:0] eg;
    logic          xfer;
    logic          rel;
    in_valid   = v;
    in_f_pix   = f;
    in_g_pix   = g;
    address_f  = af;
    address_g  = ag;
    frame_done = d;
    #1;
    chk("in_ready", in_ready, q.size() < 2);
    chk("frame_ready", frame_ready, q.size() > 0);
    ef   = ref_f(af);
    eg   = ref_g(ag);
    xfer = v && (q.size() < 2);
    rel  = d && (q.size() > 0);
    @(posedge clk);
    #1;
    if (rel) void'(q.pop_front());
    if (xfer) begin
      cur.f[cur_n] = f;
      cur.g[cur_n] = g;
      cur_n++;
      if (cur_n == FP) begin
        cur.seq = 8'(seq_cnt);
        q.push_back(cur);
        seq_cnt = (seq_cnt + 1) % 256;
        cur_n   = 0;
      end
    end
    chk("getfdata", getfdata, ef);
    chk("gdata", gdata, eg);
`ifdef PIXSRV_FRAME_SEQ_EN
    if (q.size() > 0) chk("frame_seq", frame_seq, q[0].seq);
`endif
  endtask

  function automatic logic [PW-1:0] rp();
    return PW'($urandom_range(0, (1 << PW) - 1));
  endfunction

  function automatic logic [AW-1:0] ra();
    return AW'($urandom_range(0, (1 << AW) - 1));
  endfunction

  initial begin
    logic [PW-1:0] f9;
    logic [PW-1:0] g9;
    errors = 0;
    checks = 0;
    model_reset();

    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_frame_ready", frame_ready, 1'b0);
    chk("rst_getfdata", getfdata, '0);
    chk("rst_gdata", gdata, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known frame, then a read at f=2 / g=0.
    cycle(1'b1, 3'd1, 3'd7, '0, '0, 1'b0);
    cycle(1'b1, 3'd2, 3'd6, '0, '0, 1'b0);
    cycle(1'b1, 3'd3, 3'd5, '0, '0, 1'b0);
    cycle(1'b1, 3'd4, 3'd4, '0, '0, 1'b0);
    chk("frame_ready_rise", frame_ready, 1'b1);
    cycle(1'b0, '0, '0, 3'd2, 3'd0, 1'b0);
    chk("known_f", getfdata, 3'd3);
    chk("known_g", gdata, 3'd7);
`ifdef PIXSRV_FRAME_SEQ_EN
    chk("known_seq", frame_seq, 8'd0);
`endif

    // Sweep all addresses including out-of-range ones.
    for (int a = 0; a < (1 << AW); a++) begin
      cycle(1'b0, '0, '0, AW'(a), AW'((1 << AW) - 1 - a), 1'b0);
    end

    // Fill the second bank; a held 9th pair must wait for frame_done.
    for (int i = 0; i < FP; i++) cycle(1'b1, rp(), rp(), ra(), ra(), 1'b0);
    chk("both_full_stall", in_ready, 1'b0);
    f9 = rp();
    g9 = rp();
    repeat (3) cycle(1'b1, f9, g9, ra(), ra(), 1'b0);
    cycle(1'b1, f9, g9, ra(), ra(), 1'b1);
    cycle(1'b1, f9, g9, ra(), ra(), 1'b0);

    // Drain, then a frame_done with nothing ready must be ignored.
    cycle(1'b0, '0, '0, ra(), ra(), 1'b1);
    cycle(1'b0, '0, '0, 3'd1, 3'd2, 1'b1);
    chk("idle_done_f", getfdata, '0);
    chk("idle_done_g", gdata, '0);
    cycle(1'b0, '0, '0, 3'd0, 3'd3, 1'b0);

    // Complete frame A, then release A on the same edge that completes B.
    while (cur_n != 0) cycle(1'b1, rp(), rp(), ra(), ra(), 1'b0);
    for (int i = 0; i < FP - 1; i++) cycle(1'b1, rp(), rp(), ra(), ra(), 1'b0);
    cycle(1'b1, rp(), rp(), ra(), ra(), 1'b1);
    chk("swap_frame_ready", frame_ready, 1'b1);
    for (int a = 0; a < FP; a++) cycle(1'b0, '0, '0, AW'(a), AW'(a), 1'b0);

    // Random traffic.
    repeat (400) begin
      cycle($urandom_range(0, 3) != 0, rp(), rp(), ra(), ra(), $urandom_range(0, 5) == 0);
    end

    // Asynchronous reset with a frame ready and a partial frame in flight.
    cycle(1'b0, '0, '0, ra(), ra(), 1'b1);
    cycle(1'b0, '0, '0, ra(), ra(), 1'b1);
    while (cur_n != 0) cycle(1'b1, rp(), rp(), ra(), ra(), 1'b0);
    for (int i = 0; i < FP; i++) cycle(1'b1, 3'd5, 3'd6, '0, '0, 1'b0);
    cycle(1'b1, rp(), rp(), '0, '0, 1'b0);
    cycle(1'b1, rp(), rp(), '0, '0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_frame_ready", frame_ready, 1'b0);
    chk("arst_getfdata", getfdata, '0);
    chk("arst_gdata", gdata, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < FP; i++) cycle(1'b1, rp(), rp(), ra(), ra(), 1'b0);
    chk("post_rst_ready", frame_ready, 1'b1);
    cycle(1'b0, '0, '0, 3'd3, 3'd1, 1'b0);
`ifdef PIXSRV_FRAME_SEQ_EN
    chk("post_rst_seq", frame_seq, 8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
